fifo_rd_arb: RTL and testbench

FIFO_RD_ARB -- requirements
Module: fifo_rd_arb

---
 rtl/fifo_rd_arb.sv | 177 +++++++++++++++++
 tb/tb_fifo_rd_arb.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_arb.sv
// fifo_rd_arb: round-robin arbiter sharing one FIFO read port among
// NUM_REQ burst requesters. A granted requester owns the port until its
// burst completes (done_o) or it drops its request (abandon). Each issued
// beat carries the owner index through an RD_LAT-deep tag pipeline so the
// returning read data can be steered back to the right requester.
module fifo_rd_arb #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 4,
  parameter int RD_LAT  = 2
) (
  input  logic                     rclk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*LEN_W-1:0] len_i,
  input  logic                     empty_i,
  output logic                     renc_o,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [NUM_REQ-1:0]       rvalid_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Two-bit encoding so that the spare codes exist and are steered home.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BURST = 2'b01
  } state_t;

  state_t             state_r, state_s;
  logic [IDX_W-1:0]   owner_r, owner_s;
  logic [IDX_W-1:0]   last_r,  last_s;
  logic [LEN_W-1:0]   cnt_r,   cnt_s;
  logic [NUM_REQ-1:0] gnt_r,   gnt_s;
  logic               busy_r,  busy_s;
  logic               done_r,  done_s;

  logic               renc_s;
  logic               win_found_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic [LEN_W-1:0]   win_len_s;
  logic [IDX_W-1:0]   cand_s;
  logic [LEN_W-1:0]   len_field_s [NUM_REQ];

  // Tag pipeline: each stage holds the one-hot owner of a beat in flight.
  logic [NUM_REQ-1:0] tag_pipe_r [RD_LAT];

  // Convert a requester index into its one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      vec[k] = (idx == IDX_W'(k));
    end
    return vec;
  endfunction

  // A read beat is issued only for the live owner while data is available;
  // holding it low during reset keeps a half-reset burst from issuing.
  assign renc_s = rst_n && (state_r == ST_BURST) && !empty_i && req_i[owner_r];

  // Round-robin winner search, starting just after the previous owner.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    win_len_s   = '0;
    cand_s      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      len_field_s[k] = len_i[k*LEN_W +: LEN_W];
    end
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s = IDX_W'((int'(last_r) + i) % NUM_REQ);
      if (!win_found_s && req_i[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
        win_len_s   = len_field_s[cand_s];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state logic: grant in IDLE, count beats / detect end or abandon in BURST.
  always_comb begin
    state_s = state_r;
    owner_s = owner_r;
    last_s  = last_r;
    cnt_s   = cnt_r;
    gnt_s   = gnt_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) begin
          state_s = ST_BURST;
          owner_s = win_idx_s;
          last_s  = win_idx_s;
          cnt_s   = win_len_s;
          gnt_s   = idx_to_onehot(win_idx_s);
          busy_s  = 1'b1;
        end else begin
          gnt_s   = '0;
          busy_s  = 1'b0;
        end
      end
      ST_BURST: begin
        if (!req_i[owner_r]) begin
          // Owner gave up: leave without a completion pulse.
          state_s = ST_IDLE;
          gnt_s   = '0;
          busy_s  = 1'b0;
        end else if (renc_s) begin
          if (cnt_r == '0) begin
            state_s = ST_IDLE;
            gnt_s   = '0;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            cnt_s   = cnt_r - LEN_W'(1'b1);
          end
        end else begin
          // FIFO empty: hold owner and count, no timeout.
          cnt_s   = cnt_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
        gnt_s   = '0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Arbiter state register with synchronous active-low reset.
  always_ff @(posedge rclk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      owner_r <= '0;
      last_r  <= IDX_W'(NUM_REQ - 1);
      cnt_r   <= '0;
      gnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      last_r  <= last_s;
      cnt_r   <= cnt_s;
      gnt_r   <= gnt_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Return-tag shift register: beat owner emerges RD_LAT cycles after issue.
  always_ff @(posedge rclk) begin
    if (!rst_n) begin
      for (int k = 0; k < RD_LAT; k++) begin
        tag_pipe_r[k] <= '0;
      end
    end else begin
      tag_pipe_r[0] <= renc_s ? gnt_r : '0;
      for (int k = 1; k < RD_LAT; k++) begin
        tag_pipe_r[k] <= tag_pipe_r[k-1];
      end
    end
  end

  assign renc_o   = renc_s;
  assign gnt_o    = gnt_r;
  assign busy_o   = busy_r;
  assign done_o   = done_r;
  assign rvalid_o = tag_pipe_r[RD_LAT-1];

endmodule

// File: tb/tb_fifo_rd_arb.sv
// Directed testbench for fifo_rd_arb (NUM_REQ=4, LEN_W=4, RD_LAT=2).
// Each scenario walks a fixed cycle table; c=0 is the first cycle in which
// the scenario's request is presented to an idle arbiter.
module tb_fifo_rd_arb;

  logic        rclk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_i;
  logic [15:0] len_i;
  logic        empty_i;
  logic        renc_o;
  logic [3:0]  gnt_o;
  logic        busy_o;
  logic        done_o;
  logic [3:0]  rvalid_o;

  int vectors     = 0;
  int miscompares = 0;

  always #5 rclk = ~rclk;

  fifo_rd_arb #(.NUM_REQ(4), .LEN_W(4), .RD_LAT(2)) dut (
    .rclk     (rclk),
    .rst_n    (rst_n),
    .req_i    (req_i),
    .len_i    (len_i),
    .empty_i  (empty_i),
    .renc_o   (renc_o),
    .gnt_o    (gnt_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .rvalid_o (rvalid_o)
  );

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_i = 4'b1111; len_i = 16'h0000; empty_i = 1'b0;
    tick();
    tick();
    #1;
    vectors++; if (gnt_o !== 4'b0000) begin miscompares++; $display("FAIL reset gnt got %b want 0000", gnt_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset busy got %b want 0", busy_o); end
    vectors++; if (done_o !== 1'b0) begin miscompares++; $display("FAIL reset done got %b want 0", done_o); end
    vectors++; if (renc_o !== 1'b0) begin miscompares++; $display("FAIL reset renc got %b want 0", renc_o); end
    vectors++; if (rvalid_o !== 4'b0000) begin miscompares++; $display("FAIL reset rvalid got %b want 0000", rvalid_o); end
    rst_n = 1'b1; req_i = 4'b0000;
    tick();
  endtask

  task automatic test_single_burst();
    logic [7:0] e_renc = 8'b0001_1110;
    logic [7:0] e_gnt0 = 8'b0001_1110;
    logic [7:0] e_done = 8'b0010_0000;
    logic [7:0] e_rv0  = 8'b0111_1000;
    len_i = 16'h0003; empty_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      req_i = (c < 5) ? 4'b0001 : 4'b0000;
      #1;
      vectors++; if (renc_o !== e_renc[c]) begin miscompares++; $display("FAIL single renc c=%0d got %b want %b", c, renc_o, e_renc[c]); end
      vectors++; if (gnt_o !== {3'b000, e_gnt0[c]}) begin miscompares++; $display("FAIL single gnt c=%0d got %b want %b", c, gnt_o, {3'b000, e_gnt0[c]}); end
      vectors++; if (busy_o !== e_gnt0[c]) begin miscompares++; $display("FAIL single busy c=%0d got %b want %b", c, busy_o, e_gnt0[c]); end
      vectors++; if (done_o !== e_done[c]) begin miscompares++; $display("FAIL single done c=%0d got %b want %b", c, done_o, e_done[c]); end
      vectors++; if (rvalid_o !== {3'b000, e_rv0[c]}) begin miscompares++; $display("FAIL single rvalid c=%0d got %b want %b", c, rvalid_o, {3'b000, e_rv0[c]}); end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] e_gnt [10] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
    logic [3:0] e_rv  [10] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8};
    logic [9:0] e_renc = 10'b10_1010_1010;
    logic [9:0] e_done = 10'b01_0101_0100;
    rst_n = 1'b0; req_i = 4'b0000; tick(); rst_n = 1'b1;
    len_i = 16'h0000; empty_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      req_i = 4'b1111;
      #1;
      vectors++; if (gnt_o !== e_gnt[c]) begin miscompares++; $display("FAIL rr gnt c=%0d got %b want %b", c, gnt_o, e_gnt[c]); end
      vectors++; if (renc_o !== e_renc[c]) begin miscompares++; $display("FAIL rr renc c=%0d got %b want %b", c, renc_o, e_renc[c]); end
      vectors++; if (done_o !== e_done[c]) begin miscompares++; $display("FAIL rr done c=%0d got %b want %b", c, done_o, e_done[c]); end
      vectors++; if (rvalid_o !== e_rv[c]) begin miscompares++; $display("FAIL rr rvalid c=%0d got %b want %b", c, rvalid_o, e_rv[c]); end
      tick();
    end
    req_i = 4'b0000;
    tick(); tick(); tick();
  endtask

  task automatic test_empty_gaps();
    logic [11:0] e_renc  = 12'h3E2;
    logic [11:0] e_gnt2  = 12'h3FE;
    logic [11:0] e_done  = 12'h400;
    logic [11:0] e_rv2   = 12'hF88;
    logic [11:0] e_empty = 12'h01C;
    for (int c = 0; c < 12; c++) begin
      req_i   = (c < 10) ? 4'b0100 : 4'b0000;
      len_i   = (c < 3) ? 16'h0500 : 16'hFFFF;
      empty_i = e_empty[c];
      #1;
      vectors++; if (renc_o !== e_renc[c]) begin miscompares++; $display("FAIL empty renc c=%0d got %b want %b", c, renc_o, e_renc[c]); end
      vectors++; if (gnt_o !== {1'b0, e_gnt2[c], 2'b00}) begin miscompares++; $display("FAIL empty gnt c=%0d got %b want %b", c, gnt_o, {1'b0, e_gnt2[c], 2'b00}); end
      vectors++; if (done_o !== e_done[c]) begin miscompares++; $display("FAIL empty done c=%0d got %b want %b", c, done_o, e_done[c]); end
      vectors++; if (rvalid_o !== {1'b0, e_rv2[c], 2'b00}) begin miscompares++; $display("FAIL empty rvalid c=%0d got %b want %b", c, rvalid_o, {1'b0, e_rv2[c], 2'b00}); end
      tick();
    end
    empty_i = 1'b0;
  endtask

  task automatic test_abandon();
    logic [7:0] e_renc = 8'b0000_1110;
    logic [7:0] e_gnt1 = 8'b0001_1110;
    logic [7:0] e_rv1  = 8'b0011_1000;
    len_i = 16'h0070; empty_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      req_i = (c < 4) ? 4'b0010 : 4'b0000;
      #1;
      vectors++; if (renc_o !== e_renc[c]) begin miscompares++; $display("FAIL abandon renc c=%0d got %b want %b", c, renc_o, e_renc[c]); end
      vectors++; if (gnt_o !== {2'b00, e_gnt1[c], 1'b0}) begin miscompares++; $display("FAIL abandon gnt c=%0d got %b want %b", c, gnt_o, {2'b00, e_gnt1[c], 1'b0}); end
      vectors++; if (busy_o !== e_gnt1[c]) begin miscompares++; $display("FAIL abandon busy c=%0d got %b want %b", c, busy_o, e_gnt1[c]); end
      vectors++; if (done_o !== 1'b0) begin miscompares++; $display("FAIL abandon done c=%0d got %b want 0", c, done_o); end
      vectors++; if (rvalid_o !== {2'b00, e_rv1[c], 1'b0}) begin miscompares++; $display("FAIL abandon rvalid c=%0d got %b want %b", c, rvalid_o, {2'b00, e_rv1[c], 1'b0}); end
      tick();
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [3:0] e_req [8] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'hF, 4'h0, 4'h0, 4'h0};
    logic [3:0] e_gnt [8] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0};
    logic [3:0] e_rv  [8] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [7:0] e_renc = 8'b0000_0110;
    len_i = 16'h0005; empty_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      req_i = e_req[c];
      rst_n = (c == 3) ? 1'b0 : 1'b1;
      #1;
      vectors++; if (renc_o !== e_renc[c]) begin miscompares++; $display("FAIL rstmid renc c=%0d got %b want %b", c, renc_o, e_renc[c]); end
      vectors++; if (gnt_o !== e_gnt[c]) begin miscompares++; $display("FAIL rstmid gnt c=%0d got %b want %b", c, gnt_o, e_gnt[c]); end
      vectors++; if (done_o !== 1'b0) begin miscompares++; $display("FAIL rstmid done c=%0d got %b want 0", c, done_o); end
      vectors++; if (rvalid_o !== e_rv[c]) begin miscompares++; $display("FAIL rstmid rvalid c=%0d got %b want %b", c, rvalid_o, e_rv[c]); end
      tick();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [3:0] e_req [9] = '{4'h9, 4'h9, 4'h9, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0};
    logic [3:0] e_gnt [9] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0};
    logic [3:0] e_rv  [9] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h8, 4'h8, 4'h0};
    logic [8:0] e_renc = 9'b0_0011_0110;
    logic [8:0] e_done = 9'b0_0100_1000;
    rst_n = 1'b0; req_i = 4'b0000; tick(); rst_n = 1'b1;
    len_i = 16'h1001; empty_i = 1'b0;
    for (int c = 0; c < 9; c++) begin
      req_i = e_req[c];
      #1;
      vectors++; if (renc_o !== e_renc[c]) begin miscompares++; $display("FAIL b2b renc c=%0d got %b want %b", c, renc_o, e_renc[c]); end
      vectors++; if (gnt_o !== e_gnt[c]) begin miscompares++; $display("FAIL b2b gnt c=%0d got %b want %b", c, gnt_o, e_gnt[c]); end
      vectors++; if (done_o !== e_done[c]) begin miscompares++; $display("FAIL b2b done c=%0d got %b want %b", c, done_o, e_done[c]); end
      vectors++; if (rvalid_o !== e_rv[c]) begin miscompares++; $display("FAIL b2b rvalid c=%0d got %b want %b", c, rvalid_o, e_rv[c]); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_empty_gaps();
    test_abandon();
    test_reset_mid_burst();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
